conv_window_engine: RTL and testbench
=====================================

Name: conv_window_engine

Overview:
- Stage directly downstream of the padding buffer in the image-filter datapath.
- Accepts one raster-order IMG_SIZE x IMG_SIZE frame of unsigned pixels and stores it internally.
- Once the frame is complete, slides a FILTER_SIZE x FILTER_SIZE window over the zero- or replication-padded image, one multiply-accumulate per cycle.
- Emits IMG_SIZE*IMG_SIZE scaled, saturated results in raster order.

Parameters:
- DATA_WIDTH, 8: pixel width; pixels are unsigned.
- IMG_SIZE, 5: image side length; legal values 3, 5, 6, 7.
- FILTER_SIZE, 3: kernel side length; legal values 3, 5. PAD = (FILTER_SIZE-1)/2.
- COEF_WIDTH, 8: signed kernel coefficient width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation; range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_WIDTH  input pixel.
- data_valid  in  1  pixel qualifier; ignored while busy=1.
- pad_mode  in  1  0 = zero padding, 1 = replication padding. Latched with the first pixel of each frame.
- coef_wr  in  1  coefficient write strobe; ignored while busy=1.
- coef_addr  in  5  tap index, row-major (r*FILTER_SIZE+c). Writes with addr >= FILTER_SIZE^2 are ignored.
- coef_data  in  COEF_WIDTH  signed coefficient value.
- data_out  out  DATA_WIDTH  filtered pixel.
- out_valid  out  1  one-cycle qualifier for data_out.
- busy  out  1  high during the CONV state.
- frame_done  out  1  one-cycle pulse, coincident with the last out_valid of a frame.

Behaviour:
- Reset clears: all outputs to 0, all coefficients to 0, frame store to 0, counters to 0, pad latch to 0. State returns to LOAD.
- A reset asserted mid-frame or mid-CONV aborts the operation. No further out_valid is produced until a new full frame is loaded.
- FSM has two states:
  - LOAD: each data_valid writes pixel (row_cnt, col_cnt) and advances col, then row. Counters wrap to 0 after (IMG_SIZE-1, IMG_SIZE-1); that acceptance moves the FSM to CONV on the next edge.
  - CONV: busy=1. Iterates output pixel (orow, ocol) in raster order. For each output pixel, iterates tap k = 0..FILTER_SIZE^2-1, one tap per cycle. After the last tap of the last output pixel, returns to LOAD.
- Tap operand for output (orow, ocol) and tap (kr, kc):
  - Source coordinate: y = orow+kr-PAD, x = ocol+kc-PAD.
  - If y or x is out of range: zero padding uses 0; replication padding clamps y and x to [0, IMG_SIZE-1] and reads that pixel.
- Arithmetic:
  - Product = unsigned pixel (zero-extended) x signed coefficient.
  - Accumulator is signed, 24 bits; it is never allowed to overflow.
  - Tap 0 loads the accumulator with its product; taps 1..last add to it.
- Output, on the cycle after an output pixel's last-tap cycle:
  - Result = accumulator >>> SHIFT, saturated to [0, 2^DATA_WIDTH-1].
  - result is registered to data_out and out_valid=1 for exactly one cycle.
  - Tap 0 of the next output pixel proceeds in that same cycle, so there are no bubbles.
- Throughput and latency:
  - One result every FILTER_SIZE^2 cycles.
  - First out_valid occurs FILTER_SIZE^2+1 cycles after the edge that accepted the last input pixel.
  - CONV lasts IMG_SIZE^2 * FILTER_SIZE^2 cycles.
- frame_done pulses with the final out_valid. That final output is registered in the first LOAD cycle.
- data_out holds its last value between out_valid pulses.
- Pixels and coefficient writes presented while busy=1 are dropped, not queued.
- A coefficient write landing in the same cycle as the last pixel of a frame is accepted.
- Coefficients persist across frames.
- pad_mode changes mid-frame have no effect on the current frame.

Test Plan:
- IMG_SIZE=3, FILTER_SIZE=3, SHIFT=0, all coefs 1, pixels 1..9, pad_mode=0 -> outputs 12,21,16,27,45,33,24,39,28. out_valid spacing 9 cycles; frame_done with the 9th output.
- Same frame and coefs, pad_mode=1 -> first output 21, centre output 45, last output 69.
- Defaults (5x5), all pixels 255, all coefs 127 -> every output 255 (saturate high). Then all coefs -1 -> every output 0 (saturate low).
- Only centre coef = 4, SHIFT=2, arbitrary frame -> output equals input frame, identity, in both pad modes.
- Assert rst_n low midway through CONV -> out_valid, busy, data_out drop to 0 immediately. Coefs read back as 0: next frame with no coef writes yields all zeros.
- data_valid and coef_wr toggled throughout CONV -> ignored; the next frame loads correctly starting at pixel (0,0).

Source files
------------

// File: rtl/conv_window_engine_if.sv
// Pixel, coefficient and result signals of the convolution window engine.
// The master side feeds pixels/coefficients; the slave side is the engine.
interface conv_window_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         data_valid;
  logic                         pad_mode;
  logic                         coef_wr;
  logic [4:0]                   coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         out_valid;
  logic                         busy;
  logic                         frame_done;

  modport master (
    output data_in, data_valid, pad_mode,
    output coef_wr, coef_addr, coef_data,
    input  data_out, out_valid, busy, frame_done
  );

  modport slave (
    input  data_in, data_valid, pad_mode,
    input  coef_wr, coef_addr, coef_data,
    output data_out, out_valid, busy, frame_done
  );
endinterface

// File: rtl/conv_window_engine.sv
// Frame-buffered 2-D convolution: loads a frame, then one MAC per cycle
// over a padded FILTER_SIZE x FILTER_SIZE window, emitting saturated pixels.
module conv_window_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_SIZE    = 5,
  parameter int FILTER_SIZE = 3,
  parameter int COEF_WIDTH  = 8,
  parameter int SHIFT       = 0
) (
  input logic clk,
  input logic rst_n,
  conv_window_engine_if.slave bus
);

  localparam int PAD  = (FILTER_SIZE - 1) / 2;
  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int NTAP = FILTER_SIZE * FILTER_SIZE;
  localparam int AW   = $clog2(NPIX);
  localparam int TW   = $clog2(NTAP);

  localparam logic [2:0] LASTI = 3'(IMG_SIZE - 1);
  localparam logic [2:0] LASTF = 3'(FILTER_SIZE - 1);
  localparam logic signed [4:0] LAST_S = 5'(IMG_SIZE - 1);
  localparam logic signed [4:0] PAD_S  = 5'(PAD);
  localparam logic signed [23:0] MAXS =
    24'((1 << DATA_WIDTH) - 1);

  typedef enum logic {
    LOAD,
    CONV
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0]        pix  [NPIX];
  logic signed [COEF_WIDTH-1:0] coef [NTAP];

  logic [AW-1:0]         lidx;
  logic                  pad_q;
  logic [2:0]            orow;
  logic [2:0]            ocol;
  logic [2:0]            kr;
  logic [2:0]            kc;
  logic signed [23:0]    acc;
  logic                  pend;
  logic                  pend_last;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ovalid;
  logic                  fdone;

  logic accept;
  logic last_pix;
  logic last_tap;
  logic last_out;
  logic coef_ok;

  assign accept   = (state == LOAD) && bus.data_valid;
  assign last_pix = (lidx == AW'(NPIX - 1));
  assign last_tap = (kr == LASTF) && (kc == LASTF);
  assign last_out = (orow == LASTI) && (ocol == LASTI);
  assign coef_ok  = (state == LOAD) && bus.coef_wr &&
                    (int'(bus.coef_addr) < NTAP);

  assign bus.data_out   = dout;
  assign bus.out_valid  = ovalid;
  assign bus.frame_done = fdone;
  assign bus.busy       = (state == CONV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: if (accept && last_pix) state_nx = CONV;
      CONV: if (last_tap && last_out) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  function automatic logic [2:0] clamp(
    input logic signed [4:0] v
  );
    if (v < 0)      return 3'd0;
    if (v > LAST_S) return LASTI;
    return v[2:0];
  endfunction

  logic signed [4:0]     ys;
  logic signed [4:0]     xs;
  logic                  oob;
  logic [AW-1:0]         raddr;
  logic [TW-1:0]         tidx;
  logic [DATA_WIDTH-1:0] opnd;
  logic signed [23:0]    prod;
  logic signed [23:0]    shd;
  logic [DATA_WIDTH-1:0] sat;

  // Out-of-window taps read a clamped pixel; zero padding masks it.
  always_comb begin
    ys = $signed({2'b00, orow}) + $signed({2'b00, kr}) - PAD_S;
    xs = $signed({2'b00, ocol}) + $signed({2'b00, kc}) - PAD_S;
    oob = (ys < 0) || (ys > LAST_S) ||
          (xs < 0) || (xs > LAST_S);
    raddr = AW'(clamp(ys)) * AW'(IMG_SIZE) + AW'(clamp(xs));
    tidx  = TW'(kr) * TW'(FILTER_SIZE) + TW'(kc);
    opnd  = (oob && !pad_q) ? '0 : pix[raddr];
    prod  = 24'($signed({1'b0, opnd})) * 24'(coef[tidx]);
    shd   = acc >>> SHIFT;
    sat   = '0;
    if (shd > MAXS)  sat = '1;
    else if (shd > 0) sat = shd[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIX; i++) pix[i] <= '0;
      for (int i = 0; i < NTAP; i++) coef[i] <= '0;
      lidx      <= '0;
      pad_q     <= 1'b0;
      orow      <= '0;
      ocol      <= '0;
      kr        <= '0;
      kc        <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      dout      <= '0;
      ovalid    <= 1'b0;
      fdone     <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      fdone  <= 1'b0;
      if (accept) begin
        pix[lidx] <= bus.data_in;
        if (lidx == '0) pad_q <= bus.pad_mode;
        lidx <= last_pix ? '0 : lidx + AW'(1);
      end
      if (coef_ok)
        coef[TW'(bus.coef_addr)] <= bus.coef_data;
      if (state == CONV) begin
        acc <= (kr == '0 && kc == '0) ? prod : acc + prod;
        pend      <= last_tap;
        pend_last <= last_tap && last_out;
        if (last_tap) begin
          kr <= '0;
          kc <= '0;
          if (ocol == LASTI) begin
            ocol <= '0;
            orow <= (orow == LASTI) ? '0 : orow + 3'd1;
          end else begin
            ocol <= ocol + 3'd1;
          end
        end else if (kc == LASTF) begin
          kc <= '0;
          kr <= kr + 3'd1;
        end else begin
          kc <= kc + 3'd1;
        end
      end else begin
        pend      <= 1'b0;
        pend_last <= 1'b0;
      end
      // Result leaves while tap 0 of the next pixel reloads acc.
      if (pend) begin
        dout   <= sat;
        ovalid <= 1'b1;
        fdone  <= pend_last;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Directed + randomized bench for conv_window_engine, checked against
// a plain-arithmetic convolution model of the padded frame.
module tb_conv_window_engine;

  localparam int DW    = 8;
  localparam int IMG   = 5;
  localparam int FS    = 3;
  localparam int CW    = 8;
  localparam int SH    = 2;
  localparam int PAD   = (FS - 1) / 2;
  localparam int NPIX  = IMG * IMG;
  localparam int NTAP  = FS * FS;
  localparam int NCONV = NPIX * NTAP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_engine_if #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW)
  ) bus ();

  conv_window_engine #(
    .DATA_WIDTH(DW), .IMG_SIZE(IMG), .FILTER_SIZE(FS),
    .COEF_WIDTH(CW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int pass_cnt = 0;
  int total = 0;
  int coef_m [NTAP];
  int frame  [NPIX];
  int expv   [NPIX];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  function automatic void model(input int pm);
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) begin
        int sum = 0;
        for (int i = 0; i < FS; i++)
          for (int j = 0; j < FS; j++) begin
            int y = r + i - PAD;
            int x = c + j - PAD;
            int p;
            bool_in: begin end
            if (y < 0 || y >= IMG || x < 0 || x >= IMG) begin
              if (pm == 0) p = 0;
              else begin
                y = (y < 0) ? 0 : (y >= IMG ? IMG - 1 : y);
                x = (x < 0) ? 0 : (x >= IMG ? IMG - 1 : x);
                p = frame[y * IMG + x];
              end
            end else p = frame[y * IMG + x];
            sum += p * coef_m[i * FS + j];
          end
        sum = sum >>> SH;
        if (sum < 0) sum = 0;
        if (sum > 255) sum = 255;
        expv[r * IMG + c] = sum;
      end
  endfunction

  task automatic idle_in();
    bus.data_valid = 1'b0;
    bus.coef_wr    = 1'b0;
    bus.data_in    = '0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    bus.pad_mode   = 1'b0;
  endtask

  task automatic junk_in();
    bus.data_valid = 1'($urandom_range(0, 1));
    bus.coef_wr    = 1'($urandom_range(0, 1));
    bus.data_in    = DW'($urandom);
    bus.coef_addr  = 5'($urandom);
    bus.coef_data  = CW'($urandom);
    bus.pad_mode   = 1'($urandom_range(0, 1));
  endtask

  task automatic wr_coef(input int addr, input int val);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 5'(addr);
    bus.coef_data = CW'(val);
    @(posedge clk); #1;
    bus.coef_wr = 1'b0;
    if (addr < NTAP) coef_m[addr] = val;
  endtask

  task automatic load_frame(input int pm, input bit gaps,
                            input bit late, input int laddr,
                            input int lval);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle_in();
        bus.data_in = DW'($urandom);
        @(posedge clk); #1;
      end
      idle_in();
      bus.data_valid = 1'b1;
      bus.data_in    = DW'(frame[i]);
      bus.pad_mode   = (i == 0) ? 1'(pm)
                       : 1'($urandom_range(0, 1));
      if (late && i == NPIX - 1) begin
        bus.coef_wr   = 1'b1;
        bus.coef_addr = 5'(laddr);
        bus.coef_data = CW'(lval);
      end
      @(posedge clk); #1;
    end
    idle_in();
    if (late && laddr < NTAP) coef_m[laddr] = lval;
    model(pm);
  endtask

  task automatic collect();
    int held = 0;
    for (int e = 1; e <= NCONV + 3; e++) begin
      bit ev;
      int j;
      if (e <= NCONV) junk_in();
      else idle_in();
      @(posedge clk); #1;
      ev = (e >= NTAP + 1) && ((e - 1) % NTAP == 0) &&
           ((e - 1) / NTAP <= NPIX);
      chk("out_valid", bus.out_valid, 32'(ev));
      chk("busy", bus.busy, 32'(e + 1 <= NCONV));
      if (ev) begin
        j = (e - 1) / NTAP - 1;
        chk("data_out", bus.data_out, expv[j]);
        chk("frame_done", bus.frame_done, 32'(j == NPIX - 1));
        held = expv[j];
      end else begin
        chk("frame_done_idle", bus.frame_done, 0);
        if (e > NTAP + 1) chk("data_hold", bus.data_out, held);
      end
    end
    idle_in();
  endtask

  task automatic rand_frame(input int lo, input int hi);
    for (int i = 0; i < NPIX; i++)
      frame[i] = $urandom_range(hi, lo);
  endtask

  initial begin
    idle_in();
    for (int i = 0; i < NTAP; i++) coef_m[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity: centre 4 with shift 2
    wr_coef(NTAP / 2, 4);
    rand_frame(0, 255);
    load_frame(0, 1'b1, 1'b0, 0, 0);
    collect();
    rand_frame(0, 255);
    load_frame(1, 1'b0, 1'b0, 0, 0);
    collect();

    // Random kernel, out-of-range writes ignored
    for (int i = 0; i < NTAP; i++)
      wr_coef(i, $urandom_range(0, 40) - 12);
    for (int a = NTAP; a < 32; a += 5)
      wr_coef(a, $urandom_range(0, 255) - 128);
    rand_frame(0, 255);
    load_frame(0, 1'b1, 1'b1, 2, -30);
    collect();
    rand_frame(0, 255);
    load_frame(1, 1'b1, 1'b1, 7, 55);
    collect();
    for (int i = 0; i < NTAP; i++)
      wr_coef(i, $urandom_range(0, 255) - 128);
    rand_frame(0, 255);
    load_frame(1, 1'b0, 1'b0, 0, 0);
    collect();

    // Saturation high then low
    for (int i = 0; i < NTAP; i++) wr_coef(i, 127);
    rand_frame(255, 255);
    load_frame(0, 1'b0, 1'b0, 0, 0);
    chk("sat_hi_model", expv[0], 255);
    collect();
    for (int i = 0; i < NTAP; i++) wr_coef(i, -1);
    load_frame(1, 1'b0, 1'b0, 0, 0);
    collect();

    // Reset during CONV
    for (int i = 0; i < NTAP; i++) wr_coef(i, 0);
    wr_coef(NTAP / 2, 4);
    rand_frame(1, 255);
    load_frame(0, 1'b0, 1'b0, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data_out", bus.data_out, 0);
    for (int i = 0; i < NTAP; i++) coef_m[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", bus.out_valid, 0);
    end
    rand_frame(1, 255);
    load_frame(1, 1'b1, 1'b0, 0, 0);
    collect();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
